// File: rtl/modmath_pkg.sv
// Shared definitions for the field-math arbiter: default field parameters,
// arbiter state encoding and the requester index width helper.
package modmath_pkg;

    localparam int P_DEFAULT     = 37;
    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        CLEAR = 2'd2
    } arb_state_t;

    // Width of a requester index; never below one bit so a port always exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping around, returned as one-hot grant plus index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    // Scan from the pointer outward; the first hit wins and later hits are ignored.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % NREQ);
            if (!any_o && req_valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin arbiter that time-shares one sequential ModMul between NREQ
// requesters and returns each result tagged with its requester index.
//
//   state | meaning
//   IDLE  | waiting for a request; grants and latches operands in one cycle
//   BUSY  | multiplier enabled; waits for done or the timeout count
//   CLEAR | result pulse on rsp_*; multiplier held in reset for the next op
module modmul_arbiter
    import modmath_pkg::*;
#(
    parameter int p       = P_DEFAULT,
    parameter int width   = WIDTH_DEFAULT,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int IW     = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*width-1:0] req_a,
    input  logic [NREQ*width-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic [width-1:0]      rsp_r,
    output logic                  rsp_err,
    output logic [width-1:0]      mul_a,
    output logic [width-1:0]      mul_b,
    output logic                  mul_enable,
    output logic                  mul_reset,
    input  logic [width-1:0]      mul_r,
    input  logic                  mul_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // The modulus only matters to the shared multiplier; reject nonsense early.
    if (p < 2) begin : g_bad_modulus
        $error("modmul_arbiter: modulus p must be at least 2");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("modmul_arbiter: NREQ must lie in 2..8");
    end

    arb_state_t       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    id_q, id_d;
    logic [width-1:0] a_q, a_d;
    logic [width-1:0] b_q, b_d;
    logic [width-1:0] r_q, r_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]  pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    logic [width-1:0] a_arr [NREQ];
    logic [width-1:0] b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*width +: width];
        assign b_arr[i] = req_b[i*width +: width];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_grant),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    // Next-state logic: grant in IDLE, count in BUSY, single result cycle in CLEAR.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        r_d       = r_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_any) begin
                    req_ready = pick_grant;
                    a_d       = a_arr[pick_idx];
                    b_d       = b_arr[pick_idx];
                    id_d      = pick_idx;
                    ptr_d     = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // done is checked first so a result arriving on the last allowed cycle is kept
                if (mul_done) begin
                    r_d     = mul_r;
                    err_d   = 1'b0;
                    state_d = CLEAR;
                end else if (cnt_d == CW'(TIMEOUT)) begin
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid  = (state_q == CLEAR);
    assign rsp_id     = id_q;
    assign rsp_r      = r_q;
    assign rsp_err    = err_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_enable = (state_q == BUSY);
    // The multiplier is cleared by the system reset and after every operation.
    assign mul_reset  = reset | (state_q == CLEAR);

endmodule

// File: tb/tb_modmul_arbiter.sv
module tb_modmul_arbiter;

    localparam int P   = 37;
    localparam int W   = 32;
    localparam int N   = 4;
    localparam int TMO = 64;
    localparam int IW  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [IW-1:0]    rsp_id;
    logic [W-1:0]     rsp_r;
    logic             rsp_err;
    logic [W-1:0]     mul_a, mul_b;
    logic             mul_enable, mul_reset;
    logic [W-1:0]     mul_r;
    logic             mul_done;

    always #5 clk = ~clk;

    modmul_arbiter #(.p(P), .width(W), .NREQ(N), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_r      (rsp_r),
        .rsp_err    (rsp_err),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_enable (mul_enable),
        .mul_reset  (mul_reset),
        .mul_r      (mul_r),
        .mul_done   (mul_done)
    );

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] prod;
        prod = {32'b0, a} * {32'b0, b};
        return W'(prod % 64'(P));
    endfunction

    // Multiplier stub: raises done on the stub_lat-th enabled cycle.
    int stub_lat = 1;
    bit stub_never = 1'b0;
    int en_cnt = 0;
    always @(posedge clk) begin
        if (mul_reset) en_cnt <= 0;
        else if (mul_enable) en_cnt <= en_cnt + 1;
    end
    assign mul_done = mul_enable && !stub_never && (en_cnt == stub_lat - 1);
    assign mul_r    = ref_mul(mul_a, mul_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    bit           pend [N];
    bit           perm [N];
    logic [W-1:0] pa [N];
    logic [W-1:0] pb [N];
    int           m_ptr = 0;
    bit           m_active = 1'b0;
    int           m_t, m_due, m_eff, m_g;
    logic [W-1:0] m_a, m_b, m_r;
    bit           m_err;
    bit           rnd_mode = 1'b0;
    bit           rst_arm = 1'b0;
    int           en_hi = 0;

    int           grants [$];
    int           gcyc [$];
    logic [W-1:0] results [$];
    bit           errs [$];
    int           rcyc [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy_or_pending();
        bit b;
        b = m_active;
        for (int i = 0; i < N; i++) b |= pend[i];
        return b;
    endfunction

    task automatic clear_logs();
        grants.delete(); gcyc.delete(); results.delete(); errs.delete(); rcyc.delete();
    endtask

    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        bit exp_rv, exp_en;
        @(negedge clk);
        if (reset) reset = 1'b0;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    pa[i]   = $urandom;
                    pb[i]   = $urandom;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[i*W +: W]    = pa[i];
            req_b[i*W +: W]    = pb[i];
        end
        if (rst_arm && m_active && cyc == m_t + 3) begin
            reset    = 1'b1;
            rst_arm  = 1'b0;
            m_active = 1'b0;
            m_ptr    = 0;
            pend[m_g] = 1'b1;
        end
        #1;
        g = -1;
        if (!reset && !m_active) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        exp_rv = m_active && (cyc == m_due);
        exp_en = m_active && (cyc > m_t) && (cyc <= m_t + m_eff);

        check("req_ready", req_ready, exp_ready);
        check("rsp_valid", rsp_valid, exp_rv);
        check("mul_enable", mul_enable, exp_en);
        check("mul_reset", mul_reset, reset || exp_rv);
        if (exp_rv) begin
            check("rsp_id", rsp_id, m_g);
            check("rsp_r", rsp_r, m_r);
            check("rsp_err", rsp_err, m_err);
        end
        if (exp_en) begin
            check("mul_a", mul_a, m_a);
            check("mul_b", mul_b, m_b);
        end
        if (reset) begin
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_r", rsp_r, 0);
            check("rst_rsp_err", rsp_err, 0);
            check("rst_mul_a", mul_a, 0);
            check("rst_mul_b", mul_b, 0);
        end

        if (mul_enable === 1'b1) en_hi++;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] === 1'b1) begin
                grants.push_back(i);
                gcyc.push_back(cyc);
            end
        end
        if (rsp_valid === 1'b1) begin
            results.push_back(rsp_r);
            errs.push_back(rsp_err);
            rcyc.push_back(cyc);
        end

        if (exp_rv) m_active = 1'b0;
        if (g >= 0) begin
            if (rnd_mode) stub_lat = $urandom_range(1, 8);
            m_active = 1'b1;
            m_t      = cyc;
            m_g      = g;
            m_a      = pa[g];
            m_b      = pb[g];
            if (!stub_never && stub_lat <= TMO) begin
                m_eff = stub_lat;
                m_r   = ref_mul(pa[g], pb[g]);
                m_err = 1'b0;
            end else begin
                m_eff = TMO;
                m_r   = '0;
                m_err = 1'b1;
            end
            m_due   = m_t + m_eff + 1;
            m_ptr   = (g + 1) % N;
            pend[g] = 1'b0;
            if (perm[g]) begin
                pend[g] = 1'b1;
                pa[g]   = $urandom;
                pb[g]   = $urandom;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && busy_or_pending(); i++) step();
        step();
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("pulse_req_ready", req_ready, 0);
        check("pulse_rsp_valid", rsp_valid, 0);
        check("pulse_mul_enable", mul_enable, 0);
        check("pulse_mul_reset", mul_reset, 1);
        @(negedge clk);
        reset    = 1'b0;
        m_ptr    = 0;
        m_active = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; perm[i] = 1'b0; pa[i] = '0; pb[i] = '0;
        end

        // Reset values while reset is held
        @(negedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_r", rsp_r, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_mul_enable", mul_enable, 0);
        check("reset_mul_a", mul_a, 0);
        check("reset_mul_b", mul_b, 0);
        check("reset_mul_reset", mul_reset, 1);
        @(negedge clk);
        reset = 1'b0;

        // Single request: 123*456 mod 37 = 33
        stub_lat = 3;
        clear_logs();
        pend[0] = 1'b1; pa[0] = 123; pb[0] = 456;
        drain();
        check("single_ngrant", grants.size(), 1);
        check("single_nrsp", results.size(), 1);
        if (grants.size() > 0) check("single_grant", grants[0], 0);
        if (results.size() > 0) check("single_r", results[0], 33);

        // All four valid from reset
        reset_pulse();
        stub_lat = 2;
        clear_logs();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1;
            pa[i]   = W'(2 * i + 2);
            pb[i]   = W'(2 * i + 3);
        end
        drain();
        check("all4_ngrant", grants.size(), 4);
        check("all4_nrsp", results.size(), 4);
        if (grants.size() == 4) begin
            check("all4_g0", grants[0], 0);
            check("all4_g1", grants[1], 1);
            check("all4_g2", grants[2], 2);
            check("all4_g3", grants[3], 3);
        end
        if (results.size() == 4) begin
            check("all4_r0", results[0], 6);
            check("all4_r1", results[1], 20);
            check("all4_r2", results[2], 5);
            check("all4_r3", results[3], 35);
        end

        // Fairness between requesters 1 and 3
        reset_pulse();
        stub_lat = 1;
        clear_logs();
        perm[1] = 1'b1; perm[3] = 1'b1;
        pend[1] = 1'b1; pend[3] = 1'b1;
        pa[1] = $urandom; pb[1] = $urandom; pa[3] = $urandom; pb[3] = $urandom;
        run(18);
        check("fair_ngrant", grants.size(), 6);
        if (grants.size() >= 6) begin
            for (int i = 0; i < 6; i++) check("fair_order", grants[i], (i % 2 == 0) ? 1 : 3);
        end
        perm[1] = 1'b0; perm[3] = 1'b0;
        drain();

        // Fixed latency 5: enable width, throughput L+2
        stub_lat = 5;
        clear_logs();
        perm[2] = 1'b1; pend[2] = 1'b1; pa[2] = $urandom; pb[2] = $urandom;
        step();
        en_hi = 0;
        run(6);
        check("lat5_enable_cycles", en_hi, 5);
        run(3);
        perm[2] = 1'b0;
        check("lat5_ngrant", grants.size(), 2);
        if (rcyc.size() > 0 && gcyc.size() > 0) check("lat5_rsp_at", rcyc[0] - gcyc[0], 6);
        if (gcyc.size() > 1) check("lat5_next_accept", gcyc[1] - gcyc[0], 7);
        drain();

        // Timeout, then a normal operation
        stub_never = 1'b1;
        clear_logs();
        pend[1] = 1'b1; pa[1] = 9; pb[1] = 9;
        drain();
        check("tmo_nrsp", results.size(), 1);
        if (results.size() > 0) begin
            check("tmo_r", results[0], 0);
            check("tmo_err", errs[0], 1);
            check("tmo_rsp_at", rcyc[0] - gcyc[0], TMO + 1);
        end
        stub_never = 1'b0;
        stub_lat = 4;
        clear_logs();
        pend[0] = 1'b1; pa[0] = 10; pb[0] = 11;
        drain();
        check("after_tmo_nrsp", results.size(), 1);
        if (results.size() > 0) begin
            check("after_tmo_r", results[0], 36);
            check("after_tmo_err", errs[0], 0);
        end

        // Done on the same cycle the timeout is reached: done wins
        stub_lat = TMO;
        clear_logs();
        pend[3] = 1'b1; pa[3] = 1000; pb[3] = 77;
        drain();
        check("tie_nrsp", results.size(), 1);
        if (results.size() > 0) begin
            check("tie_err", errs[0], 0);
            check("tie_r", results[0], ref_mul(1000, 77));
            check("tie_rsp_at", rcyc[0] - gcyc[0], TMO + 1);
        end

        // Reset on the 3rd BUSY cycle; request re-presented afterwards
        stub_lat = 6;
        clear_logs();
        rst_arm = 1'b1;
        pend[2] = 1'b1; pa[2] = 5000; pb[2] = 321;
        drain();
        check("midrst_ngrant", grants.size(), 2);
        check("midrst_nrsp", results.size(), 1);
        if (results.size() > 0) check("midrst_r", results[0], ref_mul(5000, 321));
        if (grants.size() > 1) check("midrst_regrant", grants[1], 2);

        // Random traffic with random latencies
        rnd_mode = 1'b1;
        run(400);
        rnd_mode = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
